// File: rtl/soc_periph_req_sched_pkg.sv
// Shared types, SoC memory map and address decode for the peripheral request scheduler.
package soc_periph_req_sched_pkg;

  localparam int unsigned NrSlaves       = 2;
  localparam int unsigned NB_PERIPHERALS = 10;
  localparam int unsigned DecErrIdx      = NB_PERIPHERALS;

  typedef enum int unsigned {
    Dram, Gpio, Ethernet, Spi, Timer, Uart, Plic, Clint, Rom, Debug
  } axi_slaves_t;

  typedef enum logic [63:0] {
    DebugBase    = 64'h0000_0000,
    RomBase      = 64'h0001_0000,
    ClintBase    = 64'h0200_0000,
    PlicBase     = 64'h0C00_0000,
    UartBase     = 64'h1000_0000,
    TimerBase    = 64'h1800_0000,
    SpiBase      = 64'h2000_0000,
    EthernetBase = 64'h3000_0000,
    GpioBase     = 64'h4000_0000,
    DramBase     = 64'h8000_0000
  } soc_bus_start_t;

  localparam logic [63:0] DebugLength    = 64'h1000;
  localparam logic [63:0] RomLength      = 64'h1_0000;
  localparam logic [63:0] ClintLength    = 64'hC_0000;
  localparam logic [63:0] PlicLength     = 64'h3FF_FFFF;
  localparam logic [63:0] UartLength     = 64'h1000;
  localparam logic [63:0] TimerLength    = 64'h1000;
  localparam logic [63:0] SpiLength      = 64'h80_0000;
  localparam logic [63:0] EthernetLength = 64'h1_0000;
  localparam logic [63:0] GpioLength     = 64'h1000;
  localparam logic [63:0] DramLength     = 64'h4000_0000;

  typedef struct packed {
    logic [31:0] idx;
    logic [63:0] start_addr;
    logic [63:0] end_addr;
  } addr_rule_t;

  // end_addr is exclusive.
  localparam addr_rule_t AddrMap [NB_PERIPHERALS] = '{
    '{idx: Dram,     start_addr: DramBase,     end_addr: DramBase + DramLength},
    '{idx: Gpio,     start_addr: GpioBase,     end_addr: GpioBase + GpioLength},
    '{idx: Ethernet, start_addr: EthernetBase, end_addr: EthernetBase + EthernetLength},
    '{idx: Spi,      start_addr: SpiBase,      end_addr: SpiBase + SpiLength},
    '{idx: Timer,    start_addr: TimerBase,    end_addr: TimerBase + TimerLength},
    '{idx: Uart,     start_addr: UartBase,     end_addr: UartBase + UartLength},
    '{idx: Plic,     start_addr: PlicBase,     end_addr: PlicBase + PlicLength},
    '{idx: Clint,    start_addr: ClintBase,    end_addr: ClintBase + ClintLength},
    '{idx: Rom,      start_addr: RomBase,      end_addr: RomBase + RomLength},
    '{idx: Debug,    start_addr: DebugBase,    end_addr: DebugBase + DebugLength}
  };

  typedef enum logic [0:0] {StEmpty, StFull} gnt_state_e;

  function automatic int unsigned addr_decode(logic [63:0] addr);
    int unsigned idx;
    idx = DecErrIdx;
    for (int unsigned i = 0; i < NB_PERIPHERALS; i++) begin
      if (addr >= AddrMap[i].start_addr && addr < AddrMap[i].end_addr) idx = AddrMap[i].idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/soc_periph_req_sched_if.sv
// Request / scheduled-grant / completion bundle between bus masters and the scheduler.
interface soc_periph_req_sched_if
  import soc_periph_req_sched_pkg::*;
#(
  parameter int unsigned NrMasters = NrSlaves,
  parameter int unsigned NrTargets = NB_PERIPHERALS,
  parameter int unsigned AddrWidth = 64
);
  localparam int unsigned MstW = (NrMasters > 1) ? $clog2(NrMasters) : 1;
  localparam int unsigned TgtW = $clog2(NrTargets + 1);

  logic [NrMasters-1:0]                req_valid_i;
  logic [NrMasters-1:0][AddrWidth-1:0] req_addr_i;
  logic [NrMasters-1:0]                req_ready_o;
  logic                                gnt_valid_o;
  logic                                gnt_ready_i;
  logic [MstW-1:0]                     gnt_master_o;
  logic [TgtW-1:0]                     gnt_target_o;
  logic [AddrWidth-1:0]                gnt_addr_o;
  logic                                cpl_valid_i;
  logic [MstW-1:0]                     cpl_master_i;
  logic                                idle_o;

  modport master (
    output req_valid_i, req_addr_i, gnt_ready_i, cpl_valid_i, cpl_master_i,
    input  req_ready_o, gnt_valid_o, gnt_master_o, gnt_target_o, gnt_addr_o, idle_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, gnt_ready_i, cpl_valid_i, cpl_master_i,
    output req_ready_o, gnt_valid_o, gnt_master_o, gnt_target_o, gnt_addr_o, idle_o
  );
endinterface

// File: rtl/soc_rr_arbiter.sv
// Round-robin arbiter: combinational grant from an eligible vector, pointer held here.
module soc_rr_arbiter #(
  parameter int unsigned NrIn = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NrIn-1:0] i_elig,
  input  logic            i_advance,
  output logic [NrIn-1:0] o_gnt_oh,
  output logic [IdxW-1:0] o_gnt_idx,
  output logic            o_any
);
  logic [IdxW-1:0] r_ptr;
  logic [IdxW-1:0] w_ptr_d;
  logic [NrIn-1:0] w_masked;
  logic [NrIn-1:0] w_pick;

  assign o_any = |i_elig;

  // Prefer eligible inputs at/after the pointer; fall back to the lowest eligible (wrap).
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < NrIn; i++) w_masked[i] = i_elig[i] && (IdxW'(i) >= r_ptr);
    w_pick    = (|w_masked) ? w_masked : i_elig;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    for (int i = NrIn - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        o_gnt_oh    = '0;
        o_gnt_oh[i] = 1'b1;
        o_gnt_idx   = IdxW'(i);
      end
    end
  end

  always_comb begin
    w_ptr_d = r_ptr;
    if (i_advance) w_ptr_d = (o_gnt_idx == IdxW'(NrIn - 1)) ? '0 : o_gnt_idx + IdxW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ptr <= '0;
    else         r_ptr <= w_ptr_d;
  end
endmodule

// File: rtl/soc_periph_req_sched.sv
// Schedules per-master address requests onto the peripheral interconnect with
// round-robin arbitration and a one-target-at-a-time ordering rule per master.
module soc_periph_req_sched
  import soc_periph_req_sched_pkg::*;
#(
  parameter int unsigned NrMasters = NrSlaves,
  parameter int unsigned NrTargets = NB_PERIPHERALS,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned MaxTrans  = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  soc_periph_req_sched_if.slave bus
);
  localparam int unsigned MstW = (NrMasters > 1) ? $clog2(NrMasters) : 1;
  localparam int unsigned TgtW = $clog2(NrTargets + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

  logic [NrMasters-1:0][TgtW-1:0] w_dec;
  logic [NrMasters-1:0][CntW-1:0] r_cnt, w_cnt_d;
  logic [NrMasters-1:0][TgtW-1:0] r_tgt, w_tgt_d;
  logic [NrMasters-1:0]           w_elig, w_win_oh, w_inc, w_dcr;
  logic [MstW-1:0]                w_win_idx;
  logic                           w_any, w_load, w_busy;
  gnt_state_e                     r_state, w_state_d;
  logic [MstW-1:0]                r_gnt_master;
  logic [TgtW-1:0]                r_gnt_target;
  logic [AddrWidth-1:0]           r_gnt_addr;

  // A master with outstanding work may only add more to the same target.
  for (genvar m = 0; m < NrMasters; m++) begin : g_mst
    assign w_dec[m]  = TgtW'(addr_decode(64'(bus.req_addr_i[m])));
    assign w_elig[m] = bus.req_valid_i[m] &&
                       (r_cnt[m] == '0 || (r_tgt[m] == w_dec[m] && r_cnt[m] != CntMax));
    assign w_inc[m]  = w_load && w_win_oh[m];
    assign w_dcr[m]  = bus.cpl_valid_i && (bus.cpl_master_i == MstW'(m)) && (r_cnt[m] != '0);
  end

  soc_rr_arbiter #(
    .NrIn (NrMasters),
    .IdxW (MstW)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_elig    (w_elig),
    .i_advance (w_load),
    .o_gnt_oh  (w_win_oh),
    .o_gnt_idx (w_win_idx),
    .o_any     (w_any)
  );

  always_comb begin
    w_load    = 1'b0;
    w_state_d = r_state;
    if ((r_state == StEmpty || bus.gnt_ready_i) && w_any) begin
      w_load    = 1'b1;
      w_state_d = StFull;
    end else if (r_state == StFull && bus.gnt_ready_i) begin
      w_state_d = StEmpty;
    end
  end

  always_comb begin
    w_cnt_d = r_cnt;
    w_tgt_d = r_tgt;
    for (int m = 0; m < NrMasters; m++) begin
      if (w_inc[m] && !w_dcr[m])      w_cnt_d[m] = r_cnt[m] + CntW'(1);
      else if (!w_inc[m] && w_dcr[m]) w_cnt_d[m] = r_cnt[m] - CntW'(1);
      if (w_inc[m]) w_tgt_d[m] = w_dec[m];
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int m = 0; m < NrMasters; m++) if (r_cnt[m] != '0) w_busy = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StEmpty;
      r_cnt        <= '0;
      r_tgt        <= '0;
      r_gnt_master <= '0;
      r_gnt_target <= '0;
      r_gnt_addr   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_tgt   <= w_tgt_d;
      if (w_load) begin
        r_gnt_master <= w_win_idx;
        r_gnt_target <= w_dec[w_win_idx];
        r_gnt_addr   <= bus.req_addr_i[w_win_idx];
      end
    end
  end

  // Ready is combinational, so gate it with reset to clear it mid-handshake.
  assign bus.req_ready_o  = (rst_ni && w_load) ? w_win_oh : '0;
  assign bus.gnt_valid_o  = (r_state == StFull);
  assign bus.gnt_master_o = r_gnt_master;
  assign bus.gnt_target_o = r_gnt_target;
  assign bus.gnt_addr_o   = r_gnt_addr;
  assign bus.idle_o       = !w_busy && (r_state == StEmpty);

  cpl_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.cpl_valid_i |-> r_cnt[bus.cpl_master_i] != '0);

endmodule

// File: tb/tb_soc_periph_req_sched.sv
// Scenario bench for soc_periph_req_sched; expected grants queue up at stimulus time.
module tb_soc_periph_req_sched;
  typedef struct packed {
    logic       m;
    logic [3:0] t;
    logic [63:0] a;
  } exp_t;

  localparam logic [63:0] Uart0 = 64'h1000_0000;
  localparam logic [63:0] Uart1 = 64'h1000_0008;
  localparam logic [63:0] SpiA  = 64'h2000_0000;
  localparam logic [63:0] GpioA = 64'h4000_0000;
  localparam logic [63:0] TmrA  = 64'h1800_0000;
  localparam logic [63:0] RomA  = 64'h0001_0000;
  localparam logic [63:0] ClntA = 64'h0200_0000;
  localparam logic [63:0] DramA = 64'h8000_1000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t mon_e, mon_o;

  logic [63:0] bnd_addr [10] = '{64'h0, 64'hFFF, 64'h1000, 64'h7FFF_FFFF, 64'hBFFF_FFFF,
                                 64'hC000_0000, 64'h0C00_0000, 64'h0FFF_FFFE, 64'h0FFF_FFFF,
                                 64'hFFFF_FFFF_FFFF_FFFF};
  logic [3:0]  bnd_tgt  [10] = '{4'd9, 4'd9, 4'd10, 4'd10, 4'd0, 4'd10, 4'd6, 4'd6, 4'd10, 4'd10};

  soc_periph_req_sched_if #(.NrMasters(2), .NrTargets(10), .AddrWidth(64)) bus ();

  soc_periph_req_sched #(
    .NrMasters (2),
    .NrTargets (10),
    .AddrWidth (64),
    .MaxTrans  (8)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every accepted grant must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.gnt_valid_o && bus.gnt_ready_i) begin
      mon_o = '{m: bus.gnt_master_o, t: bus.gnt_target_o, a: bus.gnt_addr_o};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL grant_unexpected: got m%0d t%0d a=%h, none expected",
                 mon_o.m, mon_o.t, mon_o.a);
      end else begin
        mon_e = sb.pop_front();
        if (mon_o !== mon_e) begin
          n_err++;
          $display("FAIL grant: got m%0d t%0d a=%h want m%0d t%0d a=%h",
                   mon_o.m, mon_o.t, mon_o.a, mon_e.m, mon_e.t, mon_e.a);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d pending grants want 0", sb.size());
    end
    sb.delete();
    bus.req_valid_i  = '0;
    bus.req_addr_i   = '0;
    bus.gnt_ready_i  = 1'b0;
    bus.cpl_valid_i  = 1'b0;
    bus.cpl_master_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid_i   = 2'b01;
    bus.req_addr_i[0] = 64'h8000_0000;
    bus.gnt_ready_i   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt_valid_o, bus.req_ready_o, bus.gnt_master_o, bus.gnt_target_o, bus.gnt_addr_o,
         bus.idle_o} !== {1'b0, 2'b00, 1'b0, 4'd0, 64'd0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_state: got v%b r%b m%0d t%0d a=%h idle%b want all 0, idle 1",
               bus.gnt_valid_o, bus.req_ready_o, bus.gnt_master_o, bus.gnt_target_o,
               bus.gnt_addr_o, bus.idle_o);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready_o !== 2'b01) begin
      n_err++;
      $display("FAIL rst_first_ready: got %b want 01", bus.req_ready_o);
    end
    sb.push_back('{m: 1'b0, t: 4'd0, a: 64'h8000_0000});
    cyc();
    bus.req_valid_i = '0;
    @(negedge clk);
    n_cmp++;
    if (bus.gnt_valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_latency: got gnt_valid %b want 1", bus.gnt_valid_o);
    end
    cyc();
    bus.cpl_valid_i  = 1'b1;
    bus.cpl_master_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt_valid_o, bus.idle_o} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_outstanding: got valid%b idle%b want 0 0", bus.gnt_valid_o, bus.idle_o);
    end
    cyc();
    bus.cpl_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.idle_o !== 1'b1) begin
      n_err++;
      $display("FAIL rst_idle_after_cpl: got %b want 1", bus.idle_o);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    do_reset();
    bus.gnt_ready_i   = 1'b1;
    bus.req_valid_i   = 2'b11;
    bus.req_addr_i[0] = Uart0;
    bus.req_addr_i[1] = Uart1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (bus.req_ready_o !== want) begin
        n_err++;
        $display("FAIL rr_ready[%0d]: got %b want %b", k, bus.req_ready_o, want);
      end
      if (k > 0) begin
        n_cmp++;
        if (bus.gnt_valid_o !== 1'b1) begin
          n_err++;
          $display("FAIL rr_bubble[%0d]: got gnt_valid %b want 1", k, bus.gnt_valid_o);
        end
      end
      sb.push_back('{m: want[1], t: 4'd5, a: bus.req_addr_i[want[1]]});
      cyc();
    end
    bus.req_valid_i = '0;
    @(negedge clk);
    cyc();
    @(negedge clk);
    n_cmp++;
    if (bus.gnt_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL rr_drain: got gnt_valid %b want 0", bus.gnt_valid_o);
    end
  endtask

  // Master 0 stalls behind an outstanding transaction to a different target.
  task automatic test_target_block(input logic [63:0] first_a, input logic [3:0] first_t,
                                   input logic [63:0] next_a, input logic [3:0] next_t,
                                   input bit other_master);
    logic [1:0] want;
    do_reset();
    bus.gnt_ready_i   = 1'b1;
    bus.req_valid_i   = 2'b01;
    bus.req_addr_i[0] = first_a;
    bus.req_addr_i[1] = TmrA;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready_o !== 2'b01) begin
      n_err++;
      $display("FAIL blk_first_ready: got %b want 01", bus.req_ready_o);
    end
    sb.push_back('{m: 1'b0, t: first_t, a: first_a});
    cyc();
    bus.req_addr_i[0] = next_a;
    for (int k = 0; k < 4; k++) begin
      bus.req_valid_i[1] = other_master && (k == 2);
      bus.cpl_valid_i    = (k == 3);
      bus.cpl_master_i   = 1'b0;
      want = (other_master && k == 2) ? 2'b10 : 2'b00;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready_o !== want) begin
        n_err++;
        $display("FAIL blk_stall[%0d]: got %b want %b", k, bus.req_ready_o, want);
      end
      if (want == 2'b10) sb.push_back('{m: 1'b1, t: 4'd4, a: TmrA});
      cyc();
    end
    bus.req_valid_i = 2'b01;
    bus.cpl_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready_o !== 2'b01) begin
      n_err++;
      $display("FAIL blk_release: got %b want 01", bus.req_ready_o);
    end
    sb.push_back('{m: 1'b0, t: next_t, a: next_a});
    cyc();
    bus.req_valid_i = '0;
    @(negedge clk);
    cyc();
  endtask

  task automatic test_decode_bounds();
    do_reset();
    bus.gnt_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.req_valid_i   = 2'b01;
      bus.req_addr_i[0] = bnd_addr[k];
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready_o !== 2'b01) begin
        n_err++;
        $display("FAIL dec_ready[%0d]: got %b want 01", k, bus.req_ready_o);
      end
      sb.push_back('{m: 1'b0, t: bnd_tgt[k], a: bnd_addr[k]});
      cyc();
      bus.req_valid_i  = '0;
      bus.cpl_valid_i  = 1'b1;
      bus.cpl_master_i = 1'b0;
      @(negedge clk);
      cyc();
      bus.cpl_valid_i = 1'b0;
    end
  endtask

  task automatic test_max_trans();
    logic [1:0] want;
    do_reset();
    bus.gnt_ready_i   = 1'b1;
    bus.req_valid_i   = 2'b01;
    bus.req_addr_i[0] = ClntA;
    bus.cpl_master_i  = 1'b0;
    // 8 loads, 3 stalled cycles (completion in the last), a load with a coincident
    // completion (count unchanged at 7), one more load to 8, then stalled again.
    for (int k = 0; k < 14; k++) begin
      bus.cpl_valid_i = (k == 10) || (k == 11);
      want = (k < 8 || k == 11 || k == 12) ? 2'b01 : 2'b00;
      @(negedge clk);
      n_cmp++;
      if (bus.req_ready_o !== want) begin
        n_err++;
        $display("FAIL max_ready[%0d]: got %b want %b", k, bus.req_ready_o, want);
      end
      if (k == 9) begin
        n_cmp++;
        if (bus.gnt_valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL max_empty: got gnt_valid %b want 0", bus.gnt_valid_o);
        end
      end
      if (want == 2'b01) sb.push_back('{m: 1'b0, t: 4'd7, a: ClntA});
      cyc();
    end
    bus.req_valid_i = '0;
    bus.cpl_valid_i = 1'b0;
    @(negedge clk);
    cyc();
  endtask

  task automatic test_hold();
    do_reset();
    bus.req_valid_i   = 2'b01;
    bus.req_addr_i[0] = DramA;
    bus.req_addr_i[1] = Uart1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready_o !== 2'b01) begin
      n_err++;
      $display("FAIL hold_load: got %b want 01", bus.req_ready_o);
    end
    sb.push_back('{m: 1'b0, t: 4'd0, a: DramA});
    cyc();
    bus.req_valid_i = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.gnt_valid_o, bus.gnt_master_o, bus.gnt_target_o, bus.gnt_addr_o, bus.req_ready_o}
          !== {1'b1, 1'b0, 4'd0, DramA, 2'b00}) begin
        n_err++;
        $display("FAIL hold_stable[%0d]: got v%b m%0d t%0d a=%h r%b want v1 m0 t0 a=%h r00", k,
                 bus.gnt_valid_o, bus.gnt_master_o, bus.gnt_target_o, bus.gnt_addr_o,
                 bus.req_ready_o, DramA);
      end
      cyc();
    end
    bus.gnt_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.req_ready_o !== 2'b10) begin
      n_err++;
      $display("FAIL hold_reload: got %b want 10", bus.req_ready_o);
    end
    sb.push_back('{m: 1'b1, t: 4'd5, a: Uart1});
    cyc();
    bus.req_valid_i = '0;
    @(negedge clk);
    cyc();
    // Reload M1 into a held slot, then pull reset while it waits.
    bus.gnt_ready_i = 1'b0;
    bus.req_valid_i = 2'b10;
    cyc();
    @(negedge clk);
    n_cmp++;
    if ({bus.gnt_valid_o, bus.gnt_master_o} !== 2'b11) begin
      n_err++;
      $display("FAIL hold_m1: got v%b m%0d want v1 m1", bus.gnt_valid_o, bus.gnt_master_o);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.gnt_valid_o, bus.req_ready_o, bus.gnt_master_o, bus.gnt_target_o, bus.gnt_addr_o,
         bus.idle_o} !== {1'b0, 2'b00, 1'b0, 4'd0, 64'd0, 1'b1}) begin
      n_err++;
      $display("FAIL hold_async_rst: got v%b r%b m%0d t%0d a=%h idle%b want all 0, idle 1",
               bus.gnt_valid_o, bus.req_ready_o, bus.gnt_master_o, bus.gnt_target_o,
               bus.gnt_addr_o, bus.idle_o);
    end
  endtask

  initial begin
    rst_n            = 1'b1;
    bus.req_valid_i  = '0;
    bus.req_addr_i   = '0;
    bus.gnt_ready_i  = 1'b0;
    bus.cpl_valid_i  = 1'b0;
    bus.cpl_master_i = '0;
    #1 rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_target_block(SpiA, 4'd3, GpioA, 4'd1, 1'b1);
    test_target_block(64'h5000_0000, 4'd10, RomA, 4'd8, 1'b0);
    test_decode_bounds();
    test_max_trans();
    test_hold();
    do_reset();
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
